// File: rtl/acoustics_pkg.sv
// Shared definitions for the acoustics datapath: UART arbiter state encoding and requester indices.
package acoustics_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  localparam logic REQ_CMD = 1'b0;
  localparam logic REQ_CC  = 1'b1;

  // One-hot transmitter ownership for a requester index.
  function automatic logic [1:0] grant_onehot(input logic req);
    return (req == REQ_CC) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter.sv
// Two-source UART transmit arbiter: per-byte valid/ack handshake, burst locking and
// round-robin arbitration between bursts, with a sticky timeout when the UART never goes busy.
module uart_tx_arbiter
  import acoustics_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 4096,
  parameter int TO_W         = 13
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              Req0_Valid,
  input  logic [DATA_W-1:0] Req0_Data,
  input  logic              Req0_Last,
  output logic              Req0_Ack,
  input  logic              Req1_Valid,
  input  logic [DATA_W-1:0] Req1_Data,
  input  logic              Req1_Last,
  output logic              Req1_Ack,
  input  logic              Tx_Ready,
  output logic              TX_en,
  output logic [DATA_W-1:0] TX_Data,
  output logic [1:0]        Grant,
  output logic              Timeout_Err
);

  localparam logic [TO_W-1:0] TIMER_LIMIT = TO_W'(BUSY_TIMEOUT);
  localparam logic [TO_W-1:0] TIMER_LAST  = TO_W'(BUSY_TIMEOUT - 1);

  arb_state_t        state_r;
  logic              rr_last_r;
  logic              last_r;
  logic [TO_W-1:0]   timer_r;

  logic              winner_s;
  logic              own_valid_s;
  logic [DATA_W-1:0] own_data_s;
  logic              own_last_s;

  // A tie goes to whoever did not own the previous burst.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last_owner);
    logic w;
    if (v0 && v1) begin
      w = ~last_owner;
    end else if (v1) begin
      w = REQ_CC;
    end else begin
      w = REQ_CMD;
    end
    return w;
  endfunction

  assign winner_s    = rr_pick(Req0_Valid, Req1_Valid, rr_last_r);
  assign own_valid_s = (rr_last_r == REQ_CC) ? Req1_Valid : Req0_Valid;
  assign own_data_s  = (rr_last_r == REQ_CC) ? Req1_Data  : Req0_Data;
  assign own_last_s  = (rr_last_r == REQ_CC) ? Req1_Last  : Req0_Last;

  // Arbitration / byte-launch FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_r     <= ST_IDLE;
      rr_last_r   <= REQ_CC;
      last_r      <= 1'b0;
      timer_r     <= '0;
      TX_en       <= 1'b0;
      TX_Data     <= '0;
      Req0_Ack    <= 1'b0;
      Req1_Ack    <= 1'b0;
      Grant       <= 2'b00;
      Timeout_Err <= 1'b0;
    end else begin
      TX_en    <= 1'b0;
      Req0_Ack <= 1'b0;
      Req1_Ack <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (Req0_Valid || Req1_Valid) begin
            rr_last_r <= winner_s;
            Grant     <= grant_onehot(winner_s);
            state_r   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Owner keeps the grant while its valid is low: bursts are never split.
          if (Tx_Ready && own_valid_s) begin
            TX_Data  <= own_data_s;
            TX_en    <= 1'b1;
            Req0_Ack <= (rr_last_r == REQ_CMD);
            Req1_Ack <= (rr_last_r == REQ_CC);
            last_r   <= own_last_s;
            timer_r  <= '0;
            state_r  <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (!Tx_Ready) begin
            state_r <= ST_WAIT_DONE;
          end else if (timer_r >= TIMER_LAST) begin
            Timeout_Err <= 1'b1;
            timer_r     <= TIMER_LIMIT;
            if (last_r) begin
              Grant   <= 2'b00;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_ISSUE;
            end
          end else begin
            timer_r <= timer_r + TO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (Tx_Ready) begin
            if (last_r) begin
              Grant   <= 2'b00;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_ISSUE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          Grant   <= 2'b00;
        end
      endcase
    end
  end

endmodule
